arbitro_ula: RTL and testbench

ARBITRO_ULA -- requirements
Module: arbitro_ula

---
 rtl/arbitro_ula.sv | 161 ++++++++++++++++
 tb/tb_arbitro_ula.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_ula.sv
// arbitro_ula: two-requester round-robin arbiter in front of one shared,
// purely combinational ULA (ALU). Each accepted operation takes a short
// three-step sequence:
//   1. accept cycle (idle state),
//   2. one execute cycle in which the operands are driven to the ULA,
//   3. a respond state that holds the result until the consumer takes it.
// Only one operation is in flight at a time.
//
// Ports
//   clock, reset            rising-edge clock; asynchronous active-high reset
//   reqN_valid/ready        per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op signed operands and 5-bit ULA control code
//   ula_operandoA/B         operands to the shared ULA (0 outside execute)
//   ula_controle            ULA control code (0 outside execute)
//   ula_resultado           combinational ULA result
//   resp_valid/ready        response handshake
//   resp_id                 requester that issued the completed operation
//   resp_resultado          captured result
//   resp_zero/neg/erro      result==0, result MSB, invalid opcode
module arbitro_ula #(
  parameter int unsigned bits_palavra = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [bits_palavra-1:0] req0_a,
  input  logic [bits_palavra-1:0] req0_b,
  input  logic [4:0]              req0_op,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [bits_palavra-1:0] req1_a,
  input  logic [bits_palavra-1:0] req1_b,
  input  logic [4:0]              req1_op,
  output logic [bits_palavra-1:0] ula_operandoA,
  output logic [bits_palavra-1:0] ula_operandoB,
  output logic [4:0]              ula_controle,
  input  logic [bits_palavra-1:0] ula_resultado,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_id,
  output logic [bits_palavra-1:0] resp_resultado,
  output logic                    resp_zero,
  output logic                    resp_neg,
  output logic                    resp_erro
);

  typedef enum logic [1:0] {StOcioso, StExecuta, StResponde} estado_t;

  estado_t                 estado_q;
  logic                    ultimo_q;   // requester granted most recently
  logic                    id_q;
  logic                    erro_q;
  logic [bits_palavra-1:0] ula_a_q;
  logic [bits_palavra-1:0] ula_b_q;
  logic [4:0]              ula_ctrl_q;
  logic                    resp_valid_q;
  logic                    resp_id_q;
  logic [bits_palavra-1:0] resp_res_q;
  logic                    resp_zero_q;
  logic                    resp_neg_q;
  logic                    resp_erro_q;

  logic grant0, grant1;
  logic acc0, acc1;
  logic [bits_palavra-1:0] sel_a, sel_b;
  logic [4:0]              sel_op;
  logic                    sel_ok;

  function automatic logic op_valido(input logic [4:0] op);
    if (op[4]) return 1'b1;
    case (op[3:0])
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || ultimo_q);
    grant1 = req1_valid && (!req0_valid || !ultimo_q);
    // Gating with reset keeps ready low while reset is asserted.
    acc0   = grant0 && (estado_q == StOcioso) && !reset;
    acc1   = grant1 && (estado_q == StOcioso) && !reset;
    sel_a  = acc1 ? req1_a  : req0_a;
    sel_b  = acc1 ? req1_b  : req0_b;
    sel_op = acc1 ? req1_op : req0_op;
    sel_ok = op_valido(sel_op);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q     <= StOcioso;
      ultimo_q     <= 1'b1;
      id_q         <= 1'b0;
      erro_q       <= 1'b0;
      ula_a_q      <= '0;
      ula_b_q      <= '0;
      ula_ctrl_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_res_q   <= '0;
      resp_zero_q  <= 1'b0;
      resp_neg_q   <= 1'b0;
      resp_erro_q  <= 1'b0;
    end else begin
      unique case (estado_q)
        StOcioso: begin
          if (acc0 || acc1) begin
            ula_a_q    <= sel_a;
            ula_b_q    <= sel_b;
            // Invalid opcodes still run through the ULA, forced to Zero.
            ula_ctrl_q <= sel_ok ? sel_op : 5'b10000;
            erro_q     <= !sel_ok;
            id_q       <= acc1;
            ultimo_q   <= acc1;
            estado_q   <= StExecuta;
          end
        end
        StExecuta: begin
          ula_a_q      <= '0;
          ula_b_q      <= '0;
          ula_ctrl_q   <= '0;
          resp_valid_q <= 1'b1;
          resp_id_q    <= id_q;
          resp_erro_q  <= erro_q;
          if (erro_q) begin
            resp_res_q  <= '0;
            resp_zero_q <= 1'b1;
            resp_neg_q  <= 1'b0;
          end else begin
            resp_res_q  <= ula_resultado;
            resp_zero_q <= (ula_resultado == '0);
            resp_neg_q  <= ula_resultado[bits_palavra-1];
          end
          estado_q <= StResponde;
        end
        StResponde: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            estado_q     <= StOcioso;
          end
        end
        default: estado_q <= StOcioso;
      endcase
    end
  end

  assign req0_ready     = acc0;
  assign req1_ready     = acc1;
  assign ula_operandoA  = ula_a_q;
  assign ula_operandoB  = ula_b_q;
  assign ula_controle   = ula_ctrl_q;
  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_resultado = resp_res_q;
  assign resp_zero      = resp_zero_q;
  assign resp_neg       = resp_neg_q;
  assign resp_erro      = resp_erro_q;

endmodule

// File: tb/tb_arbitro_ula.sv
module tb_arbitro_ula;
  localparam int unsigned BW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [BW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]    req0_op, req1_op;
  logic [BW-1:0] ula_operandoA, ula_operandoB, ula_resultado, resp_resultado;
  logic [4:0]    ula_controle;
  logic          resp_valid, resp_ready, resp_id, resp_zero, resp_neg, resp_erro;

  arbitro_ula #(.bits_palavra(BW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .ula_operandoA(ula_operandoA), .ula_operandoB(ula_operandoB),
    .ula_controle(ula_controle), .ula_resultado(ula_resultado),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_resultado(resp_resultado), .resp_zero(resp_zero),
    .resp_neg(resp_neg), .resp_erro(resp_erro)
  );

  always #5 clock = ~clock;

  // Small shared-ULA model: add, sub, AND, Zero; anything else XOR.
  always_comb begin
    case (ula_controle)
      5'b00000: ula_resultado = ula_operandoA + ula_operandoB;
      5'b00101: ula_resultado = ula_operandoA - ula_operandoB;
      5'b10001: ula_resultado = ula_operandoA & ula_operandoB;
      5'b10000: ula_resultado = '0;
      default:  ula_resultado = ula_operandoA ^ ula_operandoB;
    endcase
  end

  typedef struct packed {
    logic          id;
    logic [BW-1:0] res;
    logic          z;
    logic          n;
    logic          e;
  } resp_t;

  resp_t exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  function automatic resp_t mk(input logic id, input logic [BW-1:0] res,
                               input logic z, input logic n, input logic e);
    resp_t r;
    r.id = id; r.res = res; r.z = z; r.n = n; r.e = e;
    return r;
  endfunction

  // Monitor: every taken response is compared against the scoreboard head.
  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL resp_unexpected: got id=%0d res=0x%0h, expected no response",
                 resp_id, resp_resultado);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_id", {31'd0, resp_id}, {31'd0, e.id});
        check("resp_resultado", {16'd0, resp_resultado}, {16'd0, e.res});
        check("resp_flags", {29'd0, resp_zero, resp_neg, resp_erro},
              {29'd0, e.z, e.n, e.e});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a grant and checks which requester received it.
  task automatic wait_grant(input logic exp_id, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clock);
      if (req0_ready || req1_ready) got = 1'b1;
    end
    if (!got) check({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      check(nm, {31'd0, req1_ready}, {31'd0, exp_id});
      check({nm, "_exclusive"}, {31'd0, req0_ready && req1_ready}, 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; resp_ready = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("rst_resp", {13'd0, resp_valid, resp_id, resp_zero, resp_neg, resp_erro,
                       resp_resultado}, 32'd0);
    check("rst_ula", {ula_controle, ula_operandoA[10:0], ula_operandoB}, 32'd0);
    tick();
    reset = 1'b0;

    // Both valid continuously: alternate 0,1,0,1 starting from requester 0.
    req0_a = 16'd3; req0_b = 16'd7; req0_op = 5'b00101;
    req1_a = 16'h00FF; req1_b = 16'h0F0F; req1_op = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_q.push_back(mk(1'b0, 16'hFFFC, 1'b0, 1'b1, 1'b0));
      else            exp_q.push_back(mk(1'b1, 16'h000F, 1'b0, 1'b0, 1'b0));
    end
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(k[0], "rr_grant");
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    drain();

    // Single requester 0: 5+3, latency 2 cycles after accept.
    req0_a = 16'd5; req0_b = 16'd3; req0_op = 5'b00000;
    exp_q.push_back(mk(1'b0, 16'd8, 1'b0, 1'b0, 1'b0));
    req0_valid = 1;
    wait_grant(1'b0, "single_grant");
    tick();
    req0_valid = 0;
    @(negedge clock);
    check("exec_ula", {ula_controle, ula_operandoA[10:0], ula_operandoB},
          {5'b00000, 11'd5, 16'd3});
    check("exec_no_resp", {31'd0, resp_valid}, 32'd0);
    tick();
    @(negedge clock);
    check("latency_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_ula_idle", {ula_controle, ula_operandoA[10:0], ula_operandoB}, 32'd0);
    drain();

    // Response held for 5 cycles while requester 1 waits.
    resp_ready = 0;
    exp_q.push_back(mk(1'b0, 16'd8, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 16'h000F, 1'b0, 1'b0, 1'b0));
    req0_valid = 1;
    wait_grant(1'b0, "hold_grant0");
    tick();
    req0_valid = 0; req1_valid = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_resp", {14'd0, resp_valid, resp_id, resp_resultado},
            {14'd0, 1'b1, 1'b0, 16'd8});
      check("hold_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      tick();
    end
    resp_ready = 1;
    @(negedge clock);
    check("hold_no_ready_hs", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge clock);
    check("ready_resumes", {30'd0, req0_ready, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    drain();

    // Invalid opcode from requester 1.
    req1_a = 16'd1; req1_b = 16'd2; req1_op = 5'b00111;
    exp_q.push_back(mk(1'b1, 16'd0, 1'b1, 1'b0, 1'b1));
    req1_valid = 1;
    wait_grant(1'b1, "inv_grant");
    tick();
    req1_valid = 0;
    @(negedge clock);
    check("inv_ula_controle", {27'd0, ula_controle}, 32'h10);
    drain();

    // Zero opcode.
    req0_a = 16'h1234; req0_b = 16'h5678; req0_op = 5'b10000;
    exp_q.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 1'b0));
    req0_valid = 1;
    wait_grant(1'b0, "zero_grant");
    tick();
    req0_valid = 0;
    drain();

    // Reset during execute: no stale response, first tie goes to requester 0.
    req1_a = 16'd9; req1_b = 16'd9; req1_op = 5'b00000;
    req1_valid = 1;
    wait_grant(1'b1, "rst_pre_grant");
    tick();
    reset = 1; req0_valid = 1;
    req0_a = 16'd2; req0_b = 16'd2; req0_op = 5'b00000;
    @(negedge clock);
    check("rst_exec_clear", {12'd0, resp_valid, req0_ready, req1_ready, ula_controle,
                             ula_operandoA[12:0]}, 32'd0);
    tick(); tick();
    reset = 0;
    exp_q.push_back(mk(1'b0, 16'd4, 1'b0, 1'b0, 1'b0));
    wait_grant(1'b0, "rst_first_grant");
    tick();
    req0_valid = 0; req1_valid = 0;
    drain();
    repeat (3) tick();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
